uart_calc_host: RTL and testbench
=================================

Name: uart_calc_host

Overview:
- Host-side initiator for the UART calculator link.
- Accepts two 32-bit operands and a 4-bit opcode from local logic, then transmits three 32-bit words over UART: operand A, operand B, then the opcode word.
- Then receives the 4-byte 32-bit result word and presents it with a one-cycle done pulse.
- Contains its own 8N1 bit-level serializer and deserializer; sits at the test/host end of the serial line, driving `tx` and monitoring `rx`.

Parameters:
- CYCLES_PER_BIT, 104: clk cycles per UART bit, for both TX and RX; must be >= 4.
- TIMEOUT_CYCLES, 1000000: response timeout in clk cycles; used only with CALC_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  request pulse; accepted only when busy=0.
- operand_a  in  32  first operand; sampled on the accepted start cycle.
- operand_b  in  32  second operand; sampled on the accepted start cycle.
- op_select  in  4  opcode; sampled on the accepted start cycle.
- busy  out  1  high from the cycle after acceptance until done or timeout.
- tx  out  1  UART serial out; idles high.
- rx  in  1  UART serial in; asynchronous.
- result  out  32  last received result; holds its value between transactions.
- done  out  1  one-cycle pulse when result updates.
- timeout  out  1  one-cycle pulse on response timeout; constant 0 without the macro.

Behaviour:
- Reset values: tx=1, busy=0, done=0, timeout=0, result=0. All counters and the FSM return to IDLE.
- Reset mid-operation: abandons the transfer. tx=1 on the cycle after rst is sampled; no partial result is published.
- FSM states:
  - IDLE: start=1 latches the inputs and moves to SEND. busy=1 next cycle.
  - SEND: transmits 12 bytes, then moves to WAIT_RX.
  - WAIT_RX: collects 4 bytes, then moves to DONE.
  - DONE: for one cycle, result is updated and done=1, then back to IDLE.
- start while busy=1 is ignored, and so are changes on the operand inputs.
- TX byte order:
  - Least-significant byte first within each word.
  - Sequence: A[7:0], A[15:8], A[23:16], A[31:24], then B in the same order, then {28'b0, op}[7:0], 00, 00, 00.
- TX framing:
  - 8N1: start bit 0, data bits LSB first, one stop bit 1.
  - Each bit lasts exactly CYCLES_PER_BIT cycles.
  - The start bit of byte 0 begins the cycle after start is accepted.
  - Bytes are sent back-to-back with no idle gap.
  - Total SEND duration is 120*CYCLES_PER_BIT cycles.
- RX path:
  - rx passes through a 2-flop synchronizer.
  - The receiver is enabled only in WAIT_RX; line activity in IDLE or SEND is ignored.
  - A falling edge starts a frame. The line is re-sampled at CYCLES_PER_BIT/2 (integer division).
  - If the line is high at that sample, it is a glitch: discard and return to hunting.
  - Data bits and the stop bit are sampled every CYCLES_PER_BIT after the mid-start sample.
  - Stop bit = 0 is a framing error: the byte is discarded, the byte count is unchanged, and the receiver resumes hunting after the line returns high.
- RX assembly:
  - Valid bytes fill result bytes LSB first into an internal shadow register.
  - result is written only when the 4th byte completes.
  - done rises 1 cycle after the 4th stop-bit sample; busy=0 in the same cycle as done.
- A new start accepted in the cycle after done begins a new transaction normally.

Optional Feature:
- Macro: CALC_TIMEOUT_EN.
- When defined:
  - A counter runs in WAIT_RX, cleared on entry and on each valid byte.
  - When it reaches TIMEOUT_CYCLES: timeout=1 for one cycle, result unchanged, done stays 0, busy=0, FSM returns to IDLE, partial bytes are discarded.
- When undefined: WAIT_RX waits indefinitely, timeout is tied to 0, and no counter logic is generated.

Test Plan:
- CPB=8; start with A=0x00000005, B=0x00000007, op=0x1 -> tx decodes as 05 00 00 00 07 00 00 00 01 00 00 00; start bit of byte 0 at cycle+1; busy=1 throughout.
- Same transaction; drive rx with bytes 0C 00 00 00 after SEND ends -> result=0x0000000C, done pulse exactly 1 cycle, busy=0 on that cycle.
- During SEND, pulse start with A=0xFFFFFFFF -> ignored; tx stream unchanged.
- In WAIT_RX, drive byte AA with stop=0, then 78 56 34 12 -> AA discarded; result=0x12345678.
- In WAIT_RX, drive an rx low pulse of 2 cycles at CPB=8, then 01 02 03 04 -> glitch ignored; result=0x04030201.
- Assert rst for 1 cycle mid byte 5 -> tx=1 the next cycle, busy=0, result keeps 0; a new start then sends a full 12-byte stream.
- CALC_TIMEOUT_EN, TIMEOUT_CYCLES=1000: send only 2 rx bytes -> timeout pulse 1000 cycles after the second byte, result unchanged, done never asserted.

Source files
------------

// File: rtl/uart_calc_host.sv
// uart_calc_host: host-side initiator for the UART calculator link.
// Sends operand A, operand B and the opcode word (12 bytes, LSB first, 8N1),
// then collects the 4-byte result and reports it with a one-cycle done pulse.
// Optional response timeout is built only when CALC_TIMEOUT_EN is defined.
module uart_calc_host #(
    parameter int CYCLES_PER_BIT = 104,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic [3:0]  op_select,
    output logic        busy,
    output logic        tx,
    input  logic        rx,
    output logic [31:0] result,
    output logic        done,
    output logic        timeout
);

    localparam int CW = $clog2(CYCLES_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST = CW'(CYCLES_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CYCLES_PER_BIT / 2 - 1);

    if (CYCLES_PER_BIT < 4 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("uart_calc_host: CYCLES_PER_BIT must be >= 4 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {IDLE, SEND, WAIT_RX, DONE} state_t;
    typedef enum logic [2:0] {RX_HUNT, RX_START, RX_DATA, RX_STOP, RX_RECOVER} rx_phase_t;

    state_t    state, state_next;
    rx_phase_t rx_phase;

    logic          tx_q;
    logic [95:0]   tx_data;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit;
    logic [3:0]    tx_byte;

    logic          rx_s1, rx_s2, rx_prev;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_nbits;
    logic [7:0]    rx_shift;
    logic [1:0]    rx_bytes;
    logic [23:0]   shadow;
    logic [31:0]   result_q;

    logic accept, send_last, rx_enable, byte_valid, rx_last, to_hit;

    assign accept     = (state == IDLE) && start;
    assign send_last  = (state == SEND) && (tx_cnt == BIT_LAST) && (tx_bit == 4'd9) && (tx_byte == 4'd11);
    assign rx_enable  = (state == WAIT_RX);
    assign byte_valid = rx_enable && (rx_phase == RX_STOP) && (rx_cnt == BIT_LAST) && rx_s2;
    assign rx_last    = byte_valid && (rx_bytes == 2'd3);

    // State register for the transaction sequencer
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic: send all 12 bytes, wait for 4 result bytes, report
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)     state_next = SEND;
            SEND:    if (send_last) state_next = WAIT_RX;
            WAIT_RX: begin
                if (rx_last)      state_next = DONE;
                else if (to_hit)  state_next = IDLE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded from the sequencer state
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            SEND, WAIT_RX: busy = 1'b1;
            DONE:          done = 1'b1;
            default:       ;
        endcase
    end

    // Serializer: loads the 12-byte payload on accept and shifts it out 8N1
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_q    <= 1'b1;
            tx_data <= '0;
            tx_cnt  <= '0;
            tx_bit  <= '0;
            tx_byte <= '0;
        end else if (accept) begin
            tx_q    <= 1'b0;
            tx_data <= {28'd0, op_select, operand_b, operand_a};
            tx_cnt  <= '0;
            tx_bit  <= '0;
            tx_byte <= '0;
        end else if (state == SEND) begin
            if (tx_cnt == BIT_LAST) begin
                tx_cnt <= '0;
                if (tx_bit == 4'd9) begin
                    if (tx_byte == 4'd11) begin
                        tx_q <= 1'b1;
                    end else begin
                        tx_byte <= tx_byte + 4'd1;
                        tx_bit  <= '0;
                        tx_q    <= 1'b0;
                        tx_data <= {8'h00, tx_data[95:8]};
                    end
                end else begin
                    tx_bit <= tx_bit + 4'd1;
                    tx_q   <= (tx_bit == 4'd8) ? 1'b1 : tx_data[tx_bit[2:0]];
                end
            end else begin
                tx_cnt <= tx_cnt + CW'(1);
            end
        end else begin
            tx_q <= 1'b1;
        end
    end

    assign tx = tx_q;

    // Two-flop synchronizer plus a delayed copy for falling-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // Deserializer and result assembly; idle and cleared outside WAIT_RX
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_phase <= RX_HUNT;
            rx_cnt   <= '0;
            rx_nbits <= '0;
            rx_shift <= '0;
            rx_bytes <= '0;
            shadow   <= '0;
            result_q <= '0;
        end else if (!rx_enable) begin
            rx_phase <= RX_HUNT;
            rx_cnt   <= '0;
            rx_bytes <= '0;
        end else begin
            case (rx_phase)
                RX_HUNT: begin
                    if (rx_prev && !rx_s2) begin
                        rx_phase <= RX_START;
                        rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_nbits <= '0;
                        rx_phase <= rx_s2 ? RX_HUNT : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        if (rx_nbits == 3'd7) rx_phase <= RX_STOP;
                        else                  rx_nbits <= rx_nbits + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt <= '0;
                        if (rx_s2) begin
                            case (rx_bytes)
                                2'd0:    shadow[7:0]   <= rx_shift;
                                2'd1:    shadow[15:8]  <= rx_shift;
                                2'd2:    shadow[23:16] <= rx_shift;
                                default: result_q      <= {rx_shift, shadow};
                            endcase
                            rx_bytes <= rx_bytes + 2'd1;
                            rx_phase <= RX_HUNT;
                        end else begin
                            rx_phase <= RX_RECOVER;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                RX_RECOVER: begin
                    if (rx_s2) rx_phase <= RX_HUNT;
                end
                default: rx_phase <= RX_HUNT;
            endcase
        end
    end

    assign result = result_q;

`ifdef CALC_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] to_cnt;
    logic          timeout_q;

    assign to_hit = rx_enable && !byte_valid && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Response watchdog: restarts on WAIT_RX entry and on every good byte
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= to_hit;
            if (!rx_enable || byte_valid) to_cnt <= '0;
            else                          to_cnt <= to_cnt + TW'(1);
        end
    end

    assign timeout = timeout_q;
`else
    assign to_hit  = 1'b0;
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_calc_host.sv
// tb_uart_calc_host: directed-plus-random bench for uart_calc_host at
// CYCLES_PER_BIT=8, TIMEOUT_CYCLES=1000. Expected TX bytes come from the
// operand words by shift/mask arithmetic; expected results from the RX bytes.
module tb_uart_calc_host;

    localparam int CPB = 8;
    localparam int TOC = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [3:0]  op_select;
    logic        busy;
    logic        tx;
    logic        rx;
    logic [31:0] result;
    logic        done;
    logic        timeout;

    uart_calc_host #(.CYCLES_PER_BIT(CPB), .TIMEOUT_CYCLES(TOC)) dut (
        .clk(clk), .rst(rst), .start(start),
        .operand_a(operand_a), .operand_b(operand_b), .op_select(op_select),
        .busy(busy), .tx(tx), .rx(rx), .result(result),
        .done(done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cycles = 0;
    int timeout_count = 0;
    int timeout_cyc = 0;
    int last_stop_cyc = 0;
    logic [31:0] done_result = '0;
    logic        done_busy = 1'b0;
    bit tx_bits [0:119];

    // Free-running cycle count used for latency measurements
    always @(posedge clk) cyc <= cyc + 1;

    // Record every done/timeout cycle together with what the DUT showed then
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cycles = done_cycles + 1;
            done_result = result;
            done_busy   = busy;
        end
        if (timeout === 1'b1) begin
            timeout_count = timeout_count + 1;
            timeout_cyc   = cyc;
        end
    end

    // Hard stop if the sequence below ever stalls
    initial begin
        #500us;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%08h expected=%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] modelTxByte(input logic [31:0] a, input logic [31:0] b,
                                               input logic [3:0] op, input int k);
        logic [31:0] word;
        word = (k < 4) ? a : ((k < 8) ? b : {28'd0, op});
        return 8'((word >> (8 * (k % 4))) & 32'hFF);
    endfunction

    // Present a request for one cycle, then scramble the operand inputs
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        @(negedge clk);
        checkOutput("busy_before_start", busy, 1'b0);
        start = 1'b1;
        operand_a = a;
        operand_b = b;
        op_select = op;
        @(negedge clk);
        start = 1'b0;
        operand_a = $urandom;
        operand_b = $urandom;
        op_select = 4'($urandom_range(0, 15));
    endtask

    // Sample every TX bit at its centre and compare against the model stream
    task automatic checkTxStream(input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] op, input bit inject);
        int busy_low;
        int ferr;
        logic [7:0] d;
        busy_low = 0;
        ferr = 0;
        checkOutput("start_bit_cycle1", tx, 1'b0);
        for (int c = 1; c <= 120 * CPB; c++) begin
            if (c > 1) @(negedge clk);
            if (busy !== 1'b1) busy_low++;
            if (((c - 1) % CPB) == (CPB / 2 - 1)) tx_bits[(c - 1) / CPB] = tx;
            if (inject && c == 300) begin
                start = 1'b1;
                operand_a = 32'hFFFF_FFFF;
            end
            if (inject && c == 301) start = 1'b0;
        end
        for (int k = 0; k < 12; k++) begin
            if (tx_bits[10 * k] !== 1'b0 || tx_bits[10 * k + 9] !== 1'b1) ferr++;
            for (int j = 0; j < 8; j++) d[j] = tx_bits[10 * k + 1 + j];
            checkOutput($sformatf("tx_byte%0d", k), d, modelTxByte(a, b, op, k));
        end
        checkOutput("tx_framing_errors", ferr, 0);
        checkOutput("busy_low_during_send", busy_low, 0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("tx_idle_after_send", tx, 1'b1);
        checkOutput("busy_in_wait_rx", busy, 1'b1);
    endtask

    // Drive one 8N1 frame onto rx with the chosen stop-bit value
    task automatic sendRxByte(input logic [7:0] b, input logic stop);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = frame[i];
            if (i == 9) last_stop_cyc = cyc;
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
        repeat (stop ? 2 : 2 * CPB) @(negedge clk);
    endtask

    task automatic sendRxWord(input logic [31:0] w);
        for (int i = 0; i < 4; i++) sendRxByte(8'((w >> (8 * i)) & 32'hFF), 1'b1);
    endtask

    // Wait (bounded) for the done pulse, then check its shape and payload
    task automatic expectDone(input string tag, input int done_before, input logic [31:0] exp);
        for (int i = 0; i < 60 && done_cycles == done_before; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        checkOutput({tag, "_done_cycles"}, done_cycles - done_before, 1);
        checkOutput({tag, "_result_at_done"}, done_result, exp);
        checkOutput({tag, "_busy_at_done"}, done_busy, 1'b0);
        checkOutput({tag, "_result_held"}, result, exp);
        checkOutput({tag, "_busy_after"}, busy, 1'b0);
    endtask

    initial begin
        logic [31:0] a, b, w, res_before;
        logic [3:0]  op;
        int db, tb0, ok;

        rst = 1'b1;
        start = 1'b0;
        rx = 1'b1;
        operand_a = '0;
        operand_b = '0;
        op_select = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_tx", tx, 1'b1);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_done", done, 1'b0);
        checkOutput("reset_timeout", timeout, 1'b0);
        checkOutput("reset_result", result, 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed transaction with an ignored start pulse during SEND
        $display("[TB] step 1: A=5 B=7 op=1, reply 0x0000000C");
        applyStimulus(32'h5, 32'h7, 4'h1);
        checkTxStream(32'h5, 32'h7, 4'h1, 1'b1);
        db = done_cycles;
        sendRxWord(32'h0000_000C);
        expectDone("t1", db, 32'h0000_000C);

        // Random operands, framing-error byte ahead of the real reply
        $display("[TB] step 2: framing error byte then 0x12345678");
        a = $urandom; b = $urandom; op = 4'($urandom_range(0, 15));
        applyStimulus(a, b, op);
        checkTxStream(a, b, op, 1'b0);
        db = done_cycles;
        sendRxByte(8'hAA, 1'b0);
        sendRxWord(32'h1234_5678);
        expectDone("t2", db, 32'h1234_5678);

        // Random operands, short rx glitch ahead of the reply
        $display("[TB] step 3: rx glitch then 0x04030201");
        a = $urandom; b = $urandom; op = 4'($urandom_range(0, 15));
        applyStimulus(a, b, op);
        checkTxStream(a, b, op, 1'b0);
        db = done_cycles;
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        sendRxWord(32'h0403_0201);
        expectDone("t3", db, 32'h0403_0201);

        // Reset in the middle of byte 5, then a fresh full transaction
        $display("[TB] step 4: reset mid byte 5, then new transaction");
        a = $urandom; b = $urandom; op = 4'($urandom_range(0, 15));
        applyStimulus(a, b, op);
        db = done_cycles;
        repeat (5 * 10 * CPB + 3 * CPB) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midreset_tx", tx, 1'b1);
        checkOutput("midreset_busy", busy, 1'b0);
        checkOutput("midreset_result", result, 32'h0);
        repeat (3 * CPB) @(negedge clk);
        checkOutput("midreset_tx_stays_idle", tx, 1'b1);
        checkOutput("midreset_no_done", done_cycles - db, 0);
        a = $urandom; b = $urandom; op = 4'($urandom_range(0, 15));
        applyStimulus(a, b, op);
        checkTxStream(a, b, op, 1'b0);
        w = $urandom;
        db = done_cycles;
        sendRxWord(w);
        expectDone("t4", db, w);

`ifdef CALC_TIMEOUT_EN
        // Only two reply bytes: the watchdog must end the transaction
        $display("[TB] step 5: partial reply, expect timeout");
        a = $urandom; b = $urandom; op = 4'($urandom_range(0, 15));
        applyStimulus(a, b, op);
        checkTxStream(a, b, op, 1'b0);
        db = done_cycles;
        tb0 = timeout_count;
        res_before = result;
        sendRxByte(8'h11, 1'b1);
        sendRxByte(8'h22, 1'b1);
        for (int i = 0; i < 1500 && timeout_count == tb0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        checkOutput("to_pulse_count", timeout_count - tb0, 1);
        ok = ((timeout_cyc - last_stop_cyc) >= TOC && (timeout_cyc - last_stop_cyc) <= TOC + CPB + 6) ? 1 : 0;
        checkOutput("to_latency_window", ok, 1);
        checkOutput("to_result_unchanged", result, res_before);
        checkOutput("to_no_done", done_cycles - db, 0);
        checkOutput("to_busy_after", busy, 1'b0);
        checkOutput("to_total_pulses", timeout_count, 1);
`else
        res_before = result;
        checkOutput("no_timeout_pulses", timeout_count, 0);
        checkOutput("final_result_stable", res_before, w);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
